// File: rtl/mcs_apb4_bridge.sv
// mcs_apb4_bridge
// Bridges the MicroBlaze MCS IO bus onto an APB4 master port serving up to
// NSLV slaves. Each transfer runs IDLE -> SETUP -> ACCESS -> RESP and
// completes with a one-cycle io_ready pulse. Decode errors, slave errors and
// timeouts return ERR_DATA and bump a saturating error counter.
//
// Ports
//   CLK, RESETn          clock, asynchronous active-low reset
//   io_address           MCS byte address (bits [31:24] select the bridge)
//   io_addr_strobe       request strobe, accepted only in IDLE
//   io_write_data        write data
//   io_write_strobe      write qualifier
//   io_byte_enable       write byte lanes
//   io_read_strobe       read qualifier
//   io_read_data         read data, valid only while io_ready=1 (else 0)
//   io_ready             one-cycle completion pulse
//   pADDR..pSTRB         APB4 master request signals (pSEL one-hot)
//   pRDATA, pREADY,
//   pSLVERR              per-slave APB4 responses, slave i at [i*DW +: DW]
//   err_count            saturating count of errored transfers
module mcs_apb4_bridge #(
  parameter int          DW       = 32,
  parameter int          AW       = 32,
  parameter int          NSLV     = 4,
  parameter logic [31:0] BRG_BASE = 32'hC000_0000,
  parameter int          SLV_AW   = 16,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADFA17
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [31:0]          io_address,
  input  logic                 io_addr_strobe,
  input  logic [31:0]          io_write_data,
  input  logic                 io_write_strobe,
  input  logic [3:0]           io_byte_enable,
  input  logic                 io_read_strobe,
  output logic [31:0]          io_read_data,
  output logic                 io_ready,
  output logic [AW-1:0]        pADDR,
  output logic [NSLV-1:0]      pSEL,
  output logic                 pENABLE,
  output logic                 pWRITE,
  output logic [DW-1:0]        pWDATA,
  output logic [DW/8-1:0]      pSTRB,
  input  logic [NSLV*DW-1:0]   pRDATA,
  input  logic [NSLV-1:0]      pREADY,
  input  logic [NSLV-1:0]      pSLVERR,
  output logic [7:0]           err_count
);

  localparam int          SW       = DW / 8;
  localparam int          IDXW     = (NSLV > 1) ? $clog2(NSLV) : 1;
  // The whole field between the window offset and the bridge hit byte is
  // decoded, so addresses above the last slave are reported as decode errors
  // instead of aliasing onto a lower slave.
  localparam int          IW       = 24 - SLV_AW;
  localparam logic [31:0] NSLV_U   = NSLV;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_r, state_s;
  logic [AW-1:0]     addr_r, addr_s;
  logic [DW-1:0]     wdata_r, wdata_s;
  logic [SW-1:0]     strb_r, strb_s;
  logic              write_r, write_s;
  logic [IDXW-1:0]   idx_r, idx_s;
  logic [NSLV-1:0]   sel_r, sel_s;
  logic              enable_r, enable_s;
  logic              ready_r, ready_s;
  logic [31:0]       rdata_r, rdata_s;
  logic [15:0]       cnt_r, cnt_s;
  logic [7:0]        err_cnt_r, err_cnt_s;
  logic              err_s;

  logic              hit_s;
  logic [IW-1:0]     idx_full_s;
  logic              dec_err_s;
  logic              sel_ready_s;
  logic              sel_slverr_s;
  logic [DW-1:0]     sel_rdata_s;

  assign hit_s        = (io_address[31:24] == BRG_BASE[31:24]);
  assign idx_full_s   = io_address[23:SLV_AW];
  assign dec_err_s    = (32'(idx_full_s) >= NSLV_U);
  assign sel_ready_s  = pREADY[idx_r];
  assign sel_slverr_s = pSLVERR[idx_r];
  assign sel_rdata_s  = pRDATA[idx_r*DW +: DW];

  // Next-state and next-output logic for the transfer FSM
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    strb_s   = strb_r;
    write_s  = write_r;
    idx_s    = idx_r;
    sel_s    = sel_r;
    enable_s = enable_r;
    ready_s  = 1'b0;
    rdata_s  = 32'h0000_0000;
    cnt_s    = cnt_r;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        sel_s    = '0;
        enable_s = 1'b0;
        if (io_addr_strobe && hit_s) begin
          addr_s  = AW'(io_address);
          wdata_s = DW'(io_write_data);
          write_s = io_write_strobe & ~io_read_strobe;
          strb_s  = (io_write_strobe & ~io_read_strobe) ? SW'(io_byte_enable) : '0;
          idx_s   = idx_full_s[IDXW-1:0];
          if (dec_err_s) begin
            // No slave behind this index: answer straight from the bridge.
            state_s = RESP;
            ready_s = 1'b1;
            rdata_s = ERR_DATA;
            err_s   = 1'b1;
          end else begin
            state_s                   = SETUP;
            sel_s[idx_full_s[IDXW-1:0]] = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s  = ACCESS;
        enable_s = 1'b1;
        cnt_s    = 16'd0;
      end
      ACCESS: begin
        if (sel_ready_s) begin
          state_s  = RESP;
          sel_s    = '0;
          enable_s = 1'b0;
          ready_s  = 1'b1;
          err_s    = sel_slverr_s;
          rdata_s  = sel_slverr_s ? ERR_DATA : 32'(sel_rdata_s);
        end else if (cnt_r == TO_LAST) begin
          state_s  = RESP;
          sel_s    = '0;
          enable_s = 1'b0;
          ready_s  = 1'b1;
          err_s    = 1'b1;
          rdata_s  = ERR_DATA;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      RESP: begin
        state_s  = IDLE;
        sel_s    = '0;
        enable_s = 1'b0;
        cnt_s    = 16'd0;
      end
      default: begin
        state_s  = IDLE;
        sel_s    = '0;
        enable_s = 1'b0;
        cnt_s    = 16'd0;
      end
    endcase
    if (err_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_s = err_cnt_r + 8'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State and registered-output flops
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      wdata_r   <= '0;
      strb_r    <= '0;
      write_r   <= 1'b0;
      idx_r     <= '0;
      sel_r     <= '0;
      enable_r  <= 1'b0;
      ready_r   <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      cnt_r     <= 16'd0;
      err_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      strb_r    <= strb_s;
      write_r   <= write_s;
      idx_r     <= idx_s;
      sel_r     <= sel_s;
      enable_r  <= enable_s;
      ready_r   <= ready_s;
      rdata_r   <= rdata_s;
      cnt_r     <= cnt_s;
      err_cnt_r <= err_cnt_s;
    end
  end

  assign pADDR        = addr_r;
  assign pWDATA       = wdata_r;
  assign pSTRB        = strb_r;
  assign pWRITE       = write_r;
  assign pSEL         = sel_r;
  assign pENABLE      = enable_r;
  assign io_ready     = ready_r;
  assign io_read_data = rdata_r;
  assign err_count    = err_cnt_r;

endmodule

// File: tb/tb_mcs_apb4_bridge.sv
// tb_mcs_apb4_bridge
// Scoreboard bench for mcs_apb4_bridge: each request pushes its expected
// read data and completion latency; a monitor pops and compares on io_ready.
// Slaves are modelled with per-slave wait states, stuck-not-ready and error.
module tb_mcs_apb4_bridge;

  localparam logic [31:0] ERR = 32'hDEADFA17;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          start;
    int          lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [31:0] io_address = 32'h0;
  logic        io_addr_strobe = 1'b0;
  logic [31:0] io_write_data = 32'h0;
  logic        io_write_strobe = 1'b0;
  logic [3:0]  io_byte_enable = 4'h0;
  logic        io_read_strobe = 1'b0;
  logic [31:0] io_read_data;
  logic        io_ready;
  logic [31:0] pADDR;
  logic [3:0]  pSEL;
  logic        pENABLE;
  logic        pWRITE;
  logic [31:0] pWDATA;
  logic [3:0]  pSTRB;
  logic [127:0] pRDATA;
  logic [3:0]  pREADY;
  logic [3:0]  pSLVERR;
  logic [7:0]  err_count;

  int          wait_cfg [4] = '{0, 0, 3, 1};
  logic [31:0] rdata_cfg [4] = '{32'h1111_0000, 32'h2222_0001, 32'hA5A5_0001, 32'h3333_3333};
  logic [3:0]  stuck = 4'h0;
  logic [3:0]  slverr_cfg = 4'h0;
  int          wcnt = 0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_err = 0;
  exp_t        sb_q [$];
  exp_t        mon_e;

  always #5 CLK = ~CLK;

  mcs_apb4_bridge dut (
    .CLK(CLK), .RESETn(RESETn),
    .io_address(io_address), .io_addr_strobe(io_addr_strobe),
    .io_write_data(io_write_data), .io_write_strobe(io_write_strobe),
    .io_byte_enable(io_byte_enable), .io_read_strobe(io_read_strobe),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .pADDR(pADDR), .pSEL(pSEL), .pENABLE(pENABLE), .pWRITE(pWRITE),
    .pWDATA(pWDATA), .pSTRB(pSTRB), .pRDATA(pRDATA), .pREADY(pREADY),
    .pSLVERR(pSLVERR), .err_count(err_count)
  );

  assign pRDATA  = {rdata_cfg[3], rdata_cfg[2], rdata_cfg[1], rdata_cfg[0]};
  assign pSLVERR = slverr_cfg;

  always @(posedge CLK) cyc <= cyc + 1;

  // Slave model: wcnt counts ACCESS cycles of the current transfer
  always @(posedge CLK) wcnt <= (pENABLE && (pSEL != 4'h0)) ? wcnt + 1 : 0;

  always @* begin
    pREADY = 4'h0;
    for (int i = 0; i < 4; i++)
      pREADY[i] = pSEL[i] & pENABLE & ~stuck[i] & (wcnt == wait_cfg[i]);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: bus invariants and scoreboard compare on io_ready
  always @(negedge CLK) begin
    if (RESETn) begin
      if (pSEL != 4'h0 || pENABLE) begin
        check_eq("sel_onehot", 32'($countones(pSEL) <= 1), 32'd1);
        check_eq("enable_needs_sel", 32'(!pENABLE || (pSEL != 4'h0)), 32'd1);
      end
      if (io_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_ready", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
          if (mon_e.chk) check_eq("rdata", io_read_data, mon_e.data);
        end
      end else if (io_read_data != 32'h0) begin
        check_eq("rdata_idle_zero", io_read_data, 32'h0);
      end
    end
  end

  // Called at a negedge (cycle N); returns at the negedge of cycle N+1.
  task automatic drive_req(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] exp_d, input int lat,
                           input bit is_err, input bit push);
    io_address      = addr;
    io_addr_strobe  = 1'b1;
    io_write_strobe = wr;
    io_read_strobe  = ~wr;
    io_write_data   = wd;
    io_byte_enable  = be;
    if (push) begin
      sb_q.push_back('{exp_d, !wr, cyc, lat});
      if (is_err && exp_err < 255) exp_err++;
    end
    @(negedge CLK);
    io_addr_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    io_read_strobe  = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(posedge CLK);
      n++;
    end
    check_eq("done_in_time", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    #1;
    check_eq("err_count", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_eq("rst_io_ready", 32'(io_ready), 32'd0);
    check_eq("rst_rdata", io_read_data, 32'h0);
    check_eq("rst_psel", 32'(pSEL), 32'd0);
    check_eq("rst_penable", 32'(pENABLE), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    check_eq("rst_paddr", pADDR, 32'h0);

    // Write accepted on the very first edge after release
    RESETn = 1'b1;
    drive_req(32'hC001_0004, 1'b1, 32'h1234_5678, 4'b0011, 32'h0, 3, 1'b0, 1'b1);
    check_eq("wr_setup_psel", 32'(pSEL), 32'h2);
    check_eq("wr_setup_penable", 32'(pENABLE), 32'd0);
    check_eq("wr_pstrb", 32'(pSTRB), 32'h3);
    check_eq("wr_pwdata", pWDATA, 32'h1234_5678);
    check_eq("wr_paddr", pADDR, 32'hC001_0004);
    check_eq("wr_pwrite", 32'(pWRITE), 32'd1);
    @(negedge CLK);
    check_eq("wr_access_penable", 32'(pENABLE), 32'd1);
    check_eq("wr_access_psel", 32'(pSEL), 32'h2);
    check_eq("wr_access_pwdata", pWDATA, 32'h1234_5678);
    wait_done(50);

    // Read slave2 with three wait states
    @(negedge CLK);
    drive_req(32'hC002_0000, 1'b0, 32'h0, 4'hF, 32'hA5A5_0001, 6, 1'b0, 1'b1);
    check_eq("rd_pstrb", 32'(pSTRB), 32'h0);
    check_eq("rd_pwrite", 32'(pWRITE), 32'd0);
    check_eq("rd_psel", 32'(pSEL), 32'h4);
    wait_done(50);

    // Zero-wait read of slave1
    @(negedge CLK);
    drive_req(32'hC001_0010, 1'b0, 32'h0, 4'hF, 32'h2222_0001, 3, 1'b0, 1'b1);
    wait_done(50);

    // Decode error: index 4 with four slaves
    @(negedge CLK);
    drive_req(32'hC004_0000, 1'b0, 32'h0, 4'hF, ERR, 1, 1'b1, 1'b1);
    check_eq("dec_no_psel", 32'(pSEL), 32'd0);
    wait_done(50);

    // Strobe outside the bridge window is ignored
    @(negedge CLK);
    drive_req(32'h8000_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check_eq("nohit_psel", 32'(pSEL), 32'd0);

    // Second strobe while busy is ignored
    drive_req(32'hC002_0000, 1'b0, 32'h0, 4'hF, 32'hA5A5_0001, 6, 1'b0, 1'b1);
    drive_req(32'hC001_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b0, 1'b0);
    wait_done(50);
    repeat (4) @(negedge CLK);

    // Timeout on a stuck slave0
    stuck = 4'b0001;
    drive_req(32'hC000_0000, 1'b0, 32'h0, 4'hF, ERR, 257, 1'b1, 1'b1);
    wait_done(400);
    stuck = 4'b0000;

    // Slave errors drive err_count into saturation
    slverr_cfg = 4'b1000;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      drive_req(32'hC003_0000, 1'b0, 32'h0, 4'hF, ERR, 4, 1'b1, 1'b1);
      wait_done(20);
    end
    check_eq("err_sat", 32'(err_count), 32'd255);
    slverr_cfg = 4'b0000;

    // Reset in the middle of ACCESS drops the transfer
    stuck = 4'b0001;
    @(negedge CLK);
    drive_req(32'hC000_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    check_eq("pre_rst_penable", 32'(pENABLE), 32'd1);
    RESETn = 1'b0;
    #1;
    check_eq("mid_rst_psel", 32'(pSEL), 32'd0);
    check_eq("mid_rst_penable", 32'(pENABLE), 32'd0);
    check_eq("mid_rst_ready", 32'(io_ready), 32'd0);
    check_eq("mid_rst_err", 32'(err_count), 32'd0);
    exp_err = 0;
    stuck = 4'b0000;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    repeat (5) @(negedge CLK);
    drive_req(32'h8000_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check_eq("post_rst_psel", 32'(pSEL), 32'd0);
    check_eq("post_rst_ready", 32'(io_ready), 32'd0);

    // Bridge still works after reset
    drive_req(32'hC001_0008, 1'b0, 32'h0, 4'hF, 32'h2222_0001, 3, 1'b0, 1'b1);
    wait_done(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
